// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        ModeLsr = 2'b00,
        ModeAsr = 2'b01,
        ModeLsl = 2'b10,
        ModeRor = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } shift_state_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/shift_unit_iter_if.sv
// Start/done handshake and operand/result bundle for shift_unit_iter.
interface shift_unit_iter_if
    import shift_pkg::*;
#(
    parameter int unsigned N = 8
);
    logic        start;
    shift_mode_t mode;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic        busy;
    logic        done;
    logic [N-1:0] c;
    logic [3:0]  banderas;

    modport master (
        output start, mode, a, b,
        input  busy, done, c, banderas
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, c, banderas
    );
endinterface

// File: rtl/shift_flags.sv
// NZCV flag generation from the final working value and the last bit shifted out.
module shift_flags
    import shift_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] i_result,
    input  logic         i_carry,
    input  logic         i_orig_msb,
    input  shift_mode_t  i_mode,
    output logic [3:0]   o_flags
);
    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_N] = i_result[N-1];
        o_flags[FLAG_Z] = (i_result == '0);
        o_flags[FLAG_C] = i_carry;
        // Overflow only makes sense for LSL: sign changed by the shift.
        o_flags[FLAG_V] = (i_mode == ModeLsl) && (i_result[N-1] != i_orig_msb);
    end
endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle shifter: one bit position per clock, LSR/ASR/LSL/ROR with NZCV flags.
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    shift_unit_iter_if.slave bus
);
    localparam int unsigned  CntW   = $clog2(N + 2);
    localparam logic [N:0]   LimLs  = (N + 1)'(N + 1);
    localparam logic [N:0]   LimAsr = (N + 1)'(N);

    shift_state_t     r_state, w_state_d;
    shift_mode_t      r_mode, w_mode_d;
    logic [N-1:0]     r_work, w_work_d;
    logic             r_carry, w_carry_d;
    logic             r_msb, w_msb_d;
    logic [CntW-1:0]  r_cnt, w_cnt_d;
    logic [N-1:0]     r_c;
    logic [3:0]       r_flags;

    logic [N:0]       w_b_ext;
    logic [CntW-1:0]  w_k;
    logic [3:0]       w_flags;
    logic             w_load;

    // Effective count: LSR/LSL saturate at N+1 so the carry ends up 0.
    always_comb begin
        w_b_ext = {1'b0, bus.b};
        w_k     = '0;
        unique case (bus.mode)
            ModeLsr, ModeLsl: w_k = (w_b_ext > LimLs)  ? CntW'(N + 1) : CntW'(bus.b);
            ModeAsr:          w_k = (w_b_ext > LimAsr) ? CntW'(N)     : CntW'(bus.b);
            ModeRor:          w_k = CntW'(w_b_ext % LimAsr);
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_mode_d  = r_mode;
        w_work_d  = r_work;
        w_carry_d = r_carry;
        w_msb_d   = r_msb;
        w_cnt_d   = r_cnt;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_mode_d  = bus.mode;
                    w_work_d  = bus.a;
                    w_msb_d   = bus.a[N-1];
                    w_carry_d = 1'b0;
                    w_cnt_d   = w_k;
                    w_state_d = (w_k == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                unique case (r_mode)
                    ModeLsr: begin
                        w_work_d  = {1'b0, r_work[N-1:1]};
                        w_carry_d = r_work[0];
                    end
                    ModeAsr: begin
                        w_work_d  = {r_work[N-1], r_work[N-1:1]};
                        w_carry_d = r_work[0];
                    end
                    ModeLsl: begin
                        w_work_d  = {r_work[N-2:0], 1'b0};
                        w_carry_d = r_work[N-1];
                    end
                    ModeRor: begin
                        w_work_d  = {r_work[0], r_work[N-1:1]};
                        w_carry_d = r_work[0];
                    end
                endcase
                w_cnt_d = r_cnt - 1'b1;
                if (r_cnt == CntW'(1)) begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs load on entry to DONE so they are already valid while done is high.
    assign w_load = (w_state_d == StDone) && (r_state != StDone);

    shift_flags #(
        .N (N)
    ) u_flags (
        .i_result   (w_work_d),
        .i_carry    (w_carry_d),
        .i_orig_msb (w_msb_d),
        .i_mode     (w_mode_d),
        .o_flags    (w_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_mode  <= ModeLsr;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_msb   <= 1'b0;
            r_cnt   <= '0;
            r_c     <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_d;
            r_mode  <= w_mode_d;
            r_work  <= w_work_d;
            r_carry <= w_carry_d;
            r_msb   <= w_msb_d;
            r_cnt   <= w_cnt_d;
            if (w_load) begin
                r_c     <= w_work_d;
                r_flags <= w_flags;
            end
        end
    end

    assign bus.busy     = (r_state != StIdle);
    assign bus.done     = (r_state == StDone);
    assign bus.c        = r_c;
    assign bus.banderas = r_flags;
endmodule
